// File: rtl/iq_pair_sink.sv
// Receiver for the DDC DATA_RDY/DATA_ACK word handshake.
// Reassembles I/Q word pairs and buffers them in a FWFT FIFO.
module iq_pair_sink #(
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 64,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = AW + 1
) (
  input  logic          CIC_CLK,
  input  logic          CLK_RDY,
  input  logic [15:0]   DATA_IN,
  input  logic          DATA_RDY,
  output logic          DATA_ACK,
  output logic          FLAG_F,
  input  logic          RD_EN,
  output logic [31:0]   RD_DATA,
  output logic          RD_VALID,
  output logic [LW-1:0] LEVEL,
  output logic [15:0]   OVR_CNT,
  output logic [15:0]   TMO_CNT
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_I, S_I_REL, S_Q, S_Q_REL
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   i_q, i_d;
  logic [15:0]   q_q, q_d;
  logic          ack_q, ack_d;
  logic          rdy_q;
  logic          flag_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [15:0]   ovr_q, ovr_d;
  logic [15:0]   tmo_q, tmo_d;
  logic [LW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_d;
  logic [31:0]   mem [DEPTH];
  logic          wr, pop, full, rvalid;

  assign LEVEL  = wptr_q - rptr_q;
  assign full   = (LEVEL == FULL);
  assign rvalid = (LEVEL != '0);
  assign pop    = RD_EN && rvalid;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    q_d     = q_q;
    ack_d   = ack_q;
    tmr_d   = tmr_q;
    ovr_d   = ovr_q;
    tmo_d   = tmo_q;
    wr      = 1'b0;
    unique case (state_q)
      S_I: begin
        if (DATA_RDY && !full) begin
          i_d     = DATA_IN;
          ack_d   = 1'b0;
          state_d = S_I_REL;
        end else if (DATA_RDY && !rdy_q && full) begin
          if (ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
        end
      end
      S_I_REL: begin
        if (!DATA_RDY) begin
          ack_d   = 1'b1;
          tmr_d   = '0;
          state_d = S_Q;
        end
      end
      S_Q: begin
        if (DATA_RDY) begin
          q_d     = DATA_IN;
          ack_d   = 1'b0;
          state_d = S_Q_REL;
        end else if (tmr_q == TMAX) begin
          if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
          state_d = S_I;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_Q_REL: begin
        if (!DATA_RDY) begin
          ack_d   = 1'b1;
          wr      = 1'b1;
          state_d = S_I;
        end
      end
      default: state_d = S_I;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q + (wr  ? LW'(1) : LW'(0));
    rptr_d  = rptr_q + (pop ? LW'(1) : LW'(0));
    level_d = wptr_d - rptr_d;
  end

  always_ff @(posedge CIC_CLK or negedge CLK_RDY) begin
    if (!CLK_RDY) begin
      state_q <= S_I;
      i_q     <= '0;
      q_q     <= '0;
      ack_q   <= 1'b1;
      rdy_q   <= 1'b0;
      flag_q  <= 1'b1;
      tmr_q   <= '0;
      ovr_q   <= '0;
      tmo_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      q_q     <= q_d;
      ack_q   <= ack_d;
      rdy_q   <= DATA_RDY;
      flag_q  <= (level_d != FULL);
      tmr_q   <= tmr_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage needs no reset; RD_DATA is masked while empty.
  always_ff @(posedge CIC_CLK) begin
    if (wr) mem[wptr_q[AW-1:0]] <= {i_q, q_q};
  end

  assign RD_DATA  = rvalid ? mem[rptr_q[AW-1:0]] : 32'd0;
  assign RD_VALID = rvalid;
  assign DATA_ACK = ack_q;
  assign FLAG_F   = flag_q;
  assign OVR_CNT  = ovr_q;
  assign TMO_CNT  = tmo_q;

endmodule

// File: tb/tb_iq_pair_sink.sv
// Scoreboard bench for iq_pair_sink: falling-edge sender,
// expected pairs queued on send and compared on pop.
module tb_iq_pair_sink;

  logic        CIC_CLK = 1'b0;
  logic        CLK_RDY;
  logic [15:0] DATA_IN;
  logic        DATA_RDY;
  logic        DATA_ACK;
  logic        FLAG_F;
  logic        RD_EN;
  logic [31:0] RD_DATA;
  logic        RD_VALID;
  logic [4:0]  LEVEL;
  logic [15:0] OVR_CNT;
  logic [15:0] TMO_CNT;

  iq_pair_sink dut (
    .CIC_CLK (CIC_CLK),
    .CLK_RDY (CLK_RDY),
    .DATA_IN (DATA_IN),
    .DATA_RDY(DATA_RDY),
    .DATA_ACK(DATA_ACK),
    .FLAG_F  (FLAG_F),
    .RD_EN   (RD_EN),
    .RD_DATA (RD_DATA),
    .RD_VALID(RD_VALID),
    .LEVEL   (LEVEL),
    .OVR_CNT (OVR_CNT),
    .TMO_CNT (TMO_CNT)
  );

  always #5 CIC_CLK = ~CIC_CLK;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] sb [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic pop_head(input string tag);
    logic [31:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
    chk(tag, RD_DATA, e);
    RD_EN = 1'b1;
  endtask

  // Word handshake; pop optionally coincides with the commit edge.
  task automatic send_word(input logic [15:0] w, input bit pop,
                           output bit ok);
    int n;
    ok = 1'b0;
    @(negedge CIC_CLK);
    DATA_IN  = w;
    DATA_RDY = 1'b1;
    n = 0;
    while (DATA_ACK && n < 50) begin
      @(negedge CIC_CLK);
      n++;
    end
    if (DATA_ACK) begin
      DATA_RDY = 1'b0;
      return;
    end
    DATA_RDY = 1'b0;
    if (pop) pop_head("pop_at_commit");
    @(negedge CIC_CLK);
    RD_EN = 1'b0;
    n = 0;
    while (!DATA_ACK && n < 50) begin
      @(negedge CIC_CLK);
      n++;
    end
    ok = DATA_ACK;
  endtask

  task automatic send_sample(input logic [15:0] i, input logic [15:0] q,
                             input bit pop);
    bit ok;
    send_word(i, 1'b0, ok);
    chk("ack_i", 32'(ok), 32'd1);
    send_word(q, pop, ok);
    chk("ack_q", 32'(ok), 32'd1);
    sb.push_back({i, q});
  endtask

  task automatic pop_one();
    @(negedge CIC_CLK);
    chk("rd_valid", 32'(RD_VALID), 32'd1);
    pop_head("rd_data");
    @(negedge CIC_CLK);
    RD_EN = 1'b0;
  endtask

  initial begin
    bit ok;
    bit acked;
    CLK_RDY  = 1'b0;
    DATA_IN  = '0;
    DATA_RDY = 1'b0;
    RD_EN    = 1'b0;
    repeat (2) @(negedge CIC_CLK);
    chk("rst_ack", 32'(DATA_ACK), 32'd1);
    chk("rst_flag", 32'(FLAG_F), 32'd1);
    chk("rst_valid", 32'(RD_VALID), 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_data", RD_DATA, 32'd0);
    CLK_RDY = 1'b1;

    // single sample
    send_sample(16'h1234, 16'hFEDC, 1'b0);
    chk("single_valid", 32'(RD_VALID), 32'd1);
    chk("single_level", 32'(LEVEL), 32'd1);
    pop_one();
    chk("single_empty", 32'(LEVEL), 32'd0);

    // fill to full, refused sample, drain in order
    for (int k = 0; k < 16; k++)
      send_sample(16'(16'h0100 + k), 16'(16'h8000 - k), 1'b0);
    chk("full_level", 32'(LEVEL), 32'd16);
    chk("full_flag", 32'(FLAG_F), 32'd0);
    @(negedge CIC_CLK);
    DATA_IN  = 16'h7777;
    DATA_RDY = 1'b1;
    acked = 1'b0;
    repeat (20) begin
      @(negedge CIC_CLK);
      if (!DATA_ACK) acked = 1'b1;
    end
    DATA_RDY = 1'b0;
    @(negedge CIC_CLK);
    chk("full_noack", 32'(acked), 32'd0);
    chk("ovr_cnt", 32'(OVR_CNT), 32'd1);
    chk("full_level2", 32'(LEVEL), 32'd16);
    for (int k = 0; k < 16; k++) pop_one();
    chk("drain_flag", 32'(FLAG_F), 32'd1);
    chk("drain_level", 32'(LEVEL), 32'd0);

    // simultaneous commit and pop at level 5, across pointer wrap
    for (int k = 0; k < 5; k++)
      send_sample(16'(16'hA000 + k), 16'(16'h0A00 + k), 1'b0);
    for (int k = 0; k < 40; k++) begin
      send_sample(16'($urandom), 16'($urandom), 1'b1);
      chk("cp_level", 32'(LEVEL), 32'd5);
    end
    for (int k = 0; k < 5; k++) pop_one();

    // pop while empty
    @(negedge CIC_CLK);
    RD_EN = 1'b1;
    repeat (2) @(negedge CIC_CLK);
    RD_EN = 1'b0;
    chk("empty_level", 32'(LEVEL), 32'd0);
    chk("empty_valid", 32'(RD_VALID), 32'd0);

    // timeout: I accepted, Q never presented
    send_word(16'h0001, 1'b0, ok);
    chk("tmo_ack_i", 32'(ok), 32'd1);
    repeat (63) @(negedge CIC_CLK);
    chk("tmo_early", 32'(TMO_CNT), 32'd0);
    @(negedge CIC_CLK);
    chk("tmo_cnt", 32'(TMO_CNT), 32'd1);
    chk("tmo_level", 32'(LEVEL), 32'd0);
    send_sample(16'h0002, 16'h0003, 1'b0);
    send_sample(16'h0004, 16'h0005, 1'b0);
    send_sample(16'h0006, 16'h0007, 1'b0);
    chk("pre_rst_level", 32'(LEVEL), 32'd3);
    chk("tmo_pair", RD_DATA, 32'h00020003);

    // reset in S_Q_REL
    send_word(16'h0BAD, 1'b0, ok);
    @(negedge CIC_CLK);
    DATA_IN  = 16'hCAFE;
    DATA_RDY = 1'b1;
    repeat (2) @(negedge CIC_CLK);
    chk("srel_ack", 32'(DATA_ACK), 32'd0);
    #2 CLK_RDY = 1'b0;
    #1;
    chk("arst_ack", 32'(DATA_ACK), 32'd1);
    chk("arst_flag", 32'(FLAG_F), 32'd1);
    chk("arst_valid", 32'(RD_VALID), 32'd0);
    chk("arst_level", 32'(LEVEL), 32'd0);
    chk("arst_ovr", 32'(OVR_CNT), 32'd0);
    chk("arst_tmo", 32'(TMO_CNT), 32'd0);
    chk("arst_data", RD_DATA, 32'd0);
    sb.delete();
    @(negedge CIC_CLK);
    DATA_RDY = 1'b0;
    @(negedge CIC_CLK);
    CLK_RDY = 1'b1;
    send_sample(16'hAAAA, 16'h5555, 1'b0);
    chk("post_rst_level", 32'(LEVEL), 32'd1);
    pop_one();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
